// File: rtl/alu_nzcv_seq_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states for the NZCV ALU
package alu_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_MUL, OP_LSL, OP_MOV} alu_op_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic {IDLE, MUL_RUN} alu_state_e;
endpackage

// File: rtl/alu_nzcv_seq_if.sv
// alu_nzcv_seq_if: operand valid/ready input and result/flags valid/ready output
interface alu_nzcv_seq_if #(parameter int N = 32);
  import alu_pkg::*;
  logic in_valid;
  logic in_ready;
  alu_op_e op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [N-1:0] c;
  logic [3:0] banderas;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, c, banderas);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, c, banderas);
endinterface

// File: rtl/alu_nzcv_seq_mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one partial product per step
module mul_shift_add #(parameter int N = 32) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N);
  logic [2*N-1:0] acc;
  logic [N-1:0] mcand;
  logic [CW-1:0] cnt;
  logic [N:0] sum;
  // low half holds the remaining multiplier bits; product is the post-step value
  assign sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : '0);
  assign product = {sum, acc[N-1:1]};
  assign done = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= {{N{1'b0}}, b};
      mcand <= a;
      cnt <= CW'(N - 1);
    end else if (step) begin
      acc <= product;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_nzcv_seq.sv
// alu_nzcv_seq: registered integer ALU with NZCV flags and iterative MUL
module alu_nzcv_seq
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int MUL_EN = 1
) (
  input logic clk,
  input logic rst_n,
  alu_nzcv_seq_if.slave bus
);
  localparam int SW = $clog2(N);
  alu_state_e state, state_nxt;
  logic fire, is_mul, mul_done, cf, vf;
  logic [N-1:0] res;
  logic [2*N-1:0] prod;
  logic [3:0] fl, mfl;
  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
  assign fire = bus.in_valid && bus.in_ready;
  assign is_mul = (bus.op == OP_MUL) && (MUL_EN != 0);
  always_comb begin
    cf = 1'b0;
    vf = 1'b0;
    res = '0;
    case (bus.op)
      OP_ADD: begin
        {cf, res} = {1'b0, bus.a} + {1'b0, bus.b};
        vf = (bus.a[N-1] == bus.b[N-1]) && (res[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        {cf, res} = {1'b1, bus.a} - {1'b0, bus.b};
        vf = (bus.a[N-1] != bus.b[N-1]) && (res[N-1] != bus.a[N-1]);
      end
      OP_AND: res = bus.a & bus.b;
      OP_ORR: res = bus.a | bus.b;
      OP_EOR: res = bus.a ^ bus.b;
      OP_LSL: {cf, res} = {1'b0, bus.a} << bus.b[SW-1:0];
      OP_MOV: res = bus.b;
      default: res = '0;
    endcase
    fl = '0;
    fl[FLAG_N] = res[N-1];
    fl[FLAG_Z] = res == '0;
    fl[FLAG_C] = cf;
    fl[FLAG_V] = vf;
    mfl = '0;
    mfl[FLAG_N] = prod[N-1];
    mfl[FLAG_Z] = prod[N-1:0] == '0;
    mfl[FLAG_V] = |prod[2*N-1:N];
  end
  mul_shift_add #(.N(N)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(fire && is_mul),
    .step(state == MUL_RUN),
    .a(bus.a),
    .b(bus.b),
    .done(mul_done),
    .product(prod)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? ((fire && is_mul) ? MUL_RUN : IDLE) : (mul_done ? IDLE : MUL_RUN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // a same-edge accept overrides the handoff so back-to-back results have no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.c <= '0;
      bus.banderas <= '0;
    end else if (fire && !is_mul) begin
      bus.out_valid <= 1'b1;
      bus.c <= res;
      bus.banderas <= fl;
    end else if (state == MUL_RUN && mul_done) begin
      bus.out_valid <= 1'b1;
      bus.c <= prod[N-1:0];
      bus.banderas <= mfl;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule
